fft_reorder_buffer: RTL and testbench

//  Output-side companion to the radix-2^2 SDF FFT chain.
//  The FFT emits each N-point frame in bit-reversed index order; this block buffers frames and
//  re-emits them in natural order 0..N-1 as one contiguous burst. Uses ping-pong RAM: one bank
//  is written while the other is read. Sits directly after the FFT's enable_out/out_re/out_im.

---
 rtl/fft_reorder_buffer_if.sv | 27 ++
 rtl/fft_reorder_buffer.sv | 120 ++++++++++++
 tb/tb_fft_reorder_buffer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fft_reorder_buffer_if.sv
// Sample stream bundle for the FFT reorder buffer:
// bit-reversed samples in, natural-order burst out.
interface fft_reorder_buffer_if #(
    parameter int N     = 1024,
    parameter int WIDTH = 8
);
    localparam int LG = $clog2(N);

    logic                    enable_in;
    logic signed [WIDTH-1:0] in_re;
    logic signed [WIDTH-1:0] in_im;
    logic                    enable_out;
    logic signed [WIDTH-1:0] out_re;
    logic signed [WIDTH-1:0] out_im;
    logic [LG-1:0]           out_index;
    logic                    out_last;

    modport master (
        output enable_in, in_re, in_im,
        input  enable_out, out_re, out_im, out_index, out_last
    );

    modport slave (
        input  enable_in, in_re, in_im,
        output enable_out, out_re, out_im, out_index, out_last
    );
endinterface

// File: rtl/fft_reorder_buffer.sv
// Ping-pong frame buffer: stores FFT samples in bit-reversed
// order and replays each frame as one natural-order burst.
module fft_reorder_buffer #(
    parameter int N     = 1024,
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    fft_reorder_buffer_if.slave bus
);
    localparam int            LG   = $clog2(N);
    localparam logic [LG-1:0] LAST = LG'(N - 1);

    typedef enum logic {IDLE, READ} state_t;

    function automatic logic [LG-1:0] bitrev(input logic [LG-1:0] a);
        logic [LG-1:0] r;
        for (int i = 0; i < LG; i++) r[i] = a[LG-1-i];
        return r;
    endfunction

    logic [2*WIDTH-1:0] mem [2*N];

    logic [LG-1:0]      wr_cnt;
    logic               wr_bank;
    logic               frame_done;
    state_t             state;
    state_t             state_nx;
    logic               rd_en;
    logic [LG-1:0]      rd_cnt;
    logic               rd_bank;
    logic [2*WIDTH-1:0] rd_data;
    logic               rd_vld;
    logic [LG-1:0]      rd_idx;

    assign frame_done = bus.enable_in && (wr_cnt == LAST);

    // write position within the frame and the bank being filled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (bus.enable_in) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (frame_done) wr_bank <= ~wr_bank;
        end
    end

    // storage: scattered writes, sequential synchronous reads
    always_ff @(posedge clk) begin
        if (bus.enable_in)
            mem[{wr_bank, bitrev(wr_cnt)}] <= {bus.in_re, bus.in_im};
        if (rd_en)
            rd_data <= mem[{rd_bank, rd_cnt}];
    end

    // read FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // read FSM next state: a completed frame (re)starts a burst
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (frame_done) state_nx = READ;
            READ: if (rd_cnt == LAST && !frame_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // read FSM outputs
    always_comb begin
        rd_en = (state == READ);
    end

    // burst address counter; a new frame restarts at bin 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else if (frame_done) begin
            rd_cnt  <= '0;
            rd_bank <= wr_bank;
        end else if (rd_en) begin
            rd_cnt <= rd_cnt + 1'b1;
        end
    end

    // align valid/index with the one-cycle RAM read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld <= 1'b0;
            rd_idx <= '0;
        end else begin
            rd_vld <= rd_en;
            rd_idx <= rd_cnt;
        end
    end

    // registered outputs; data and index hold between bursts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.enable_out <= 1'b0;
            bus.out_re     <= '0;
            bus.out_im     <= '0;
            bus.out_index  <= '0;
            bus.out_last   <= 1'b0;
        end else begin
            bus.enable_out <= rd_vld;
            bus.out_last   <= rd_vld && (rd_idx == LAST);
            if (rd_vld) begin
                bus.out_re    <= $signed(rd_data[2*WIDTH-1:WIDTH]);
                bus.out_im    <= $signed(rd_data[WIDTH-1:0]);
                bus.out_index <= rd_idx;
            end
        end
    end
endmodule

// File: tb/tb_fft_reorder_buffer.sv
// Scoreboard bench for fft_reorder_buffer (N=16, WIDTH=8):
// frame model in, natural-order expectations out.
module tb_fft_reorder_buffer;
    localparam int N  = 16;
    localparam int W  = 8;
    localparam int LG = 4;

    typedef struct {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
        int                  idx;
        bit                  last;
        int                  cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fft_reorder_buffer_if #(.N(N), .WIDTH(W)) bus ();

    fft_reorder_buffer #(.N(N), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int edge_no = 0;
    always @(posedge clk) edge_no++;

    exp_t                sb[$];
    logic signed [W-1:0] fr_re[$];
    logic signed [W-1:0] fr_im[$];
    int                  vectors   = 0;
    int                  errors    = 0;
    int                  last_done = -100;
    exp_t                mon_e;

    function automatic int brev(input int v);
        int r = 0;
        for (int i = 0; i < LG; i++)
            if (v[i]) r |= 1 << (LG - 1 - i);
        return r;
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    // model: a full frame of arrivals yields bins 0..N-1 where bin k
    // is the arrival at position bitrev(k), starting two edges later
    task automatic send(input logic signed [W-1:0] re, input logic signed [W-1:0] im);
        bus.enable_in = 1'b1;
        bus.in_re     = re;
        bus.in_im     = im;
        @(posedge clk);
        #1;
        bus.enable_in = 1'b0;
        fr_re.push_back(re);
        fr_im.push_back(im);
        if (fr_re.size() == N) begin
            assert (edge_no - last_done >= N)
            else $error("overrun: frames %0d edges apart", edge_no - last_done);
            last_done = edge_no;
            for (int k = 0; k < N; k++) begin
                exp_t e;
                e.re   = fr_re[brev(k)];
                e.im   = fr_im[brev(k)];
                e.idx  = k;
                e.last = (k == N - 1);
                e.cyc  = edge_no + 2 + k;
                sb.push_back(e);
            end
            fr_re.delete();
            fr_im.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int cycles);
        bus.enable_in = 1'b0;
        rst = 1'b1;
        fr_re.delete();
        fr_im.delete();
        sb.delete();
        last_done = -100;
        repeat (cycles) begin
            @(negedge clk);
            chk("reset_outputs",
                {bus.enable_out, bus.out_re, bus.out_im, bus.out_index, bus.out_last}, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk({name, "_pending"}, sb.size(), 0);
        sb.delete();
        idle(3);
    endtask

    // monitor: every presented output must be the next expected bin, on time
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.enable_out) begin
                vectors++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got idx=%0d re=%0d, required no output",
                             bus.out_index, bus.out_re);
                end else begin
                    mon_e = sb.pop_front();
                    if (bus.out_re !== mon_e.re || bus.out_im !== mon_e.im ||
                        int'(bus.out_index) != mon_e.idx ||
                        bus.out_last !== mon_e.last || edge_no != mon_e.cyc) begin
                        errors++;
                        $display("FAIL out_bin: got re=%0d im=%0d idx=%0d last=%0b edge=%0d, required re=%0d im=%0d idx=%0d last=%0b edge=%0d",
                                 bus.out_re, bus.out_im, bus.out_index, bus.out_last, edge_no,
                                 mon_e.re, mon_e.im, mon_e.idx, mon_e.last, mon_e.cyc);
                    end
                end
            end else if (sb.size() != 0 && sb[0].cyc <= edge_no) begin
                vectors++;
                errors++;
                $display("FAIL missing_out: got no output at edge %0d, required idx=%0d",
                         edge_no, sb[0].idx);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        bit found;
        bus.enable_in = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;

        do_reset(3);

        // single contiguous frame
        for (int n = 0; n < N; n++) send(W'(brev(n)), W'(-brev(n)));
        drain("single");

        // alternating gaps on input
        for (int n = 0; n < N; n++) begin
            send(W'(brev(n)), W'(-brev(n)));
            idle(1);
        end
        drain("gappy");

        // three frames back to back
        for (int f = 0; f < 3; f++)
            for (int n = 0; n < N; n++)
                send(W'(16 * f + brev(n)), W'(-(16 * f + brev(n))));
        drain("b2b");

        // reset after a partial frame
        for (int n = 0; n < 7; n++) send(W'(100 + n), W'(-100 - n));
        do_reset(3);
        for (int n = 0; n < N; n++) send(W'(brev(n)), W'(-brev(n)));
        drain("partial_reset");

        // reset in the middle of a burst
        for (int n = 0; n < N; n++) send(W'(brev(n) + 20), W'(brev(n)));
        found = 1'b0;
        for (int t = 0; t < 60 && !found; t++) begin
            @(negedge clk);
            if (bus.enable_out && bus.out_index == 4'd5) found = 1'b1;
        end
        chk("burst_idx5_seen", found, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_drop",
            {bus.enable_out, bus.out_re, bus.out_im, bus.out_index, bus.out_last}, 0);
        do_reset(2);
        idle(40);
        for (int n = 0; n < N; n++) send(W'(brev(n)), W'(-brev(n)));
        drain("after_burst_reset");

        // extreme values
        for (int n = 0; n < N; n++) send(-8'sd128, 8'sd127);
        drain("extremes");

        // random data with random gaps
        for (int f = 0; f < 6; f++) begin
            for (int n = 0; n < N; n++) begin
                send(W'($urandom), W'($urandom));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        drain("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
